delay_sched: RTL and testbench
==============================

# delay_sched

Controller and storage scheduler for a RAM-backed, programmable-depth sample delay line in the Viterbi decoder datapath, used where the fixed register-chain delay is too deep to build from flops (e.g. aligning received symbols with traceback output). With a valid/ready handshake on each side, every accepted input sample produces one output sample, equal to the input accepted D samples earlier. Zeros stand in until D samples have been seen. A flush command drains the D in-flight samples without new input.

## Interface
- Data_Width, 12, sample width in bits
- Addr_Width, 6, RAM address width; buffer holds 2^Addr_Width entries; legal D = 1 .. 2^Addr_Width-1

- mclk  in  1  clock, all logic rising-edge
- rst  in  1  asynchronous, active-low reset (logic reset while rst=0)
- cfg_load  in  1  one-cycle strobe, latch cfg_delay
- cfg_delay  in  Addr_Width  requested delay D in samples
- cfg_err  out  1  one-cycle pulse: cfg_load rejected
- flush  in  1  one-cycle strobe, start drain
- in_valid  in  1  input sample present
- in_data  in  Data_Width  input sample
- in_ready  out  1  input accepted this cycle when in_valid & in_ready
- out_valid  out  1  output sample present
- out_data  out  Data_Width  output sample
- out_ready  in  1  downstream takes sample when out_valid & out_ready
- busy  out  1  high in DRAIN
- state_o  out  2  current FSM state (debug)

## Operation
- FSM states:
  - IDLE: not configured; in_ready=0.
  - RUN: streaming.
  - DRAIN: flushing.
- Reset values: state IDLE, wp=0, fill=0, D=1, out_valid=0, out_data=0, cfg_err=0, busy=0, in_ready=0.
- cfg_load handling:
  - Accepted only in IDLE, or in RUN with fill=0 and out_valid=0.
  - cfg_delay=0 is rejected. A load in any other situation is also rejected: cfg_err pulses, D and state unchanged.
  - On acceptance: D latched, fill=0, state becomes RUN.
- RUN:
  - in_ready = !out_valid | out_ready.
  - On accept: RAM[wp] <= in_data; read address ra = wp - D (mod 2^Addr_Width), read-first.
  - Output sample = RAM read data if fill >= D, else 0.
  - wp increments with wrap; fill saturates at D.
- flush in RUN: state becomes DRAIN; in_ready drops the next cycle. An input accepted in the same cycle as flush is kept and is part of the drain.
- DRAIN:
  - Pending count P = fill, loaded at flush.
  - Each cycle with output slot free (!out_valid | out_ready) and P>0: read RAM[wp - P], emit it, decrement P.
  - When P=0 and the output slot is empty: fill=0, wp unchanged, state becomes RUN.
  - flush or cfg_load during DRAIN is ignored; cfg_load also pulses cfg_err.
- flush in IDLE is ignored.
- Output register holds its data stable while out_valid & !out_ready.
- rst asserted mid-operation: immediate return to reset values, and the configured D is lost. RAM contents are don't-care, because fill=0 masks them.

## Timing
- Latency: input accepted at edge t gives out_valid=1 with its output sample after edge t+1 (one cycle).
- Throughput: one sample per cycle while out_ready=1.
- Stall: out_ready=0 with out_valid=1 forces in_ready=0 in the same cycle (combinational).
- Drain duration with out_ready held 1: P output cycles, then RUN on the following edge.
- cfg_err asserts the cycle after the rejected cfg_load, for one cycle.
- Wrap-around: wp and read addresses are modulo 2^Addr_Width. D = 2^Addr_Width-1 must work across the wrap.

## Structure
- Shared package: state encoding constants (IDLE=0, RUN=1, DRAIN=2) and the Addr_Width default, so the traceback controller can reuse them.
- One sub-module, dp_ram: simple dual-port, one write port and one synchronous read-first read port, parameterised by Data_Width and Addr_Width.
- Scheduler FSM, pointers and output register live in delay_sched.

## Test plan
- Basic stream: reset, cfg_load D=3, feed 1,2,3,4,5,6 back-to-back with out_ready=1 -> outputs 0,0,0,1,2,3, each one cycle after its input.
- Back-pressure: D=2, out_ready low for 4 cycles mid-stream -> in_ready low the same cycles, out_data held, no sample lost or duplicated.
- Flush: D=4, feed 10..15, pulse flush -> 6 stream outputs (0,0,0,0,10,11), then drain outputs 12,13,14,15. After that, busy=0, state RUN, and the next input emits 0.
- Wrap: Addr_Width=3, D=7, feed 20 ramped samples -> output n equals input n-7 through pointer wrap.
- Config errors: cfg_delay=0 -> cfg_err pulse, state IDLE. cfg_load during DRAIN -> cfg_err pulse, D unchanged.
- Reset mid-stream: assert rst during RUN with out_valid=1 -> out_valid, in_ready and busy go to 0 immediately, state IDLE. A new cfg_load D=1 and input 7,8 give outputs 0,7.

Source files
------------

// File: rtl/delay_sched_pkg.sv
// Shared definitions for the RAM-backed delay line scheduler.
// The traceback controller reuses the same state encoding and default address width.
package delay_sched_pkg;

  localparam int DATA_WIDTH_DEF = 12;
  localparam int ADDR_WIDTH_DEF = 6;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

endpackage

// File: rtl/delay_sched_dp_ram.sv
// Simple dual-port RAM: one write port and one registered read-first read port.
module dp_ram #(
  parameter int Data_Width = 12,
  parameter int Addr_Width = 6
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [Addr_Width-1:0] waddr,
  input  logic [Data_Width-1:0] wdata,
  input  logic                  re,
  input  logic [Addr_Width-1:0] raddr,
  output logic [Data_Width-1:0] rdata
);

  logic [Data_Width-1:0] mem [2**Addr_Width];
  logic [Data_Width-1:0] rdata_q;

  // A read of the address being written returns the old contents.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/delay_sched.sv
// Programmable-depth sample delay line: scheduler FSM, pointers and output stage
// around a dual-port RAM, with valid/ready on both sides and a flush drain.
module delay_sched
  import delay_sched_pkg::*;
#(
  parameter int Data_Width = DATA_WIDTH_DEF,
  parameter int Addr_Width = ADDR_WIDTH_DEF
) (
  input  logic                  mclk,
  input  logic                  rst,
  input  logic                  cfg_load,
  input  logic [Addr_Width-1:0] cfg_delay,
  output logic                  cfg_err,
  input  logic                  flush,
  input  logic                  in_valid,
  input  logic [Data_Width-1:0] in_data,
  output logic                  in_ready,
  output logic                  out_valid,
  output logic [Data_Width-1:0] out_data,
  input  logic                  out_ready,
  output logic                  busy,
  output logic [1:0]            state_o
);

  state_e                state_q, state_d;
  logic [Addr_Width-1:0] wp_q, wp_d;
  logic [Addr_Width-1:0] fill_q, fill_d;
  logic [Addr_Width-1:0] dly_q, dly_d;
  logic [Addr_Width-1:0] pend_q, pend_d;
  logic                  out_valid_q, out_valid_d;
  logic                  zero_q, zero_d;
  logic                  cfg_err_q, cfg_err_d;

  logic                  slot_free, in_fire, cfg_ok;
  logic                  ram_we, ram_re;
  logic [Addr_Width-1:0] ram_raddr, fill_eff, dly_eff;
  logic [Data_Width-1:0] ram_rdata;

  assign slot_free = !out_valid_q || out_ready;
  assign in_ready  = (state_q == ST_RUN) && slot_free;
  assign in_fire   = in_valid && in_ready;
  assign cfg_ok    = cfg_load && (cfg_delay != '0) &&
                     ((state_q == ST_IDLE) ||
                      ((state_q == ST_RUN) && (fill_q == '0) && !out_valid_q));

  always_comb begin
    state_d     = state_q;
    wp_d        = wp_q;
    fill_d      = fill_q;
    dly_d       = dly_q;
    pend_d      = pend_q;
    out_valid_d = out_valid_q && !out_ready;
    zero_d      = zero_q;
    cfg_err_d   = cfg_load && !cfg_ok;
    ram_we      = 1'b0;
    ram_re      = 1'b0;
    ram_raddr   = wp_q - dly_q;
    fill_eff    = fill_q;
    dly_eff     = dly_q;

    // A sample accepted alongside a new configuration already uses the new delay.
    if (cfg_ok) begin
      dly_d    = cfg_delay;
      fill_d   = '0;
      state_d  = ST_RUN;
      fill_eff = '0;
      dly_eff  = cfg_delay;
    end

    case (state_q)
      ST_RUN: begin
        if (in_fire) begin
          ram_we      = 1'b1;
          ram_re      = 1'b1;
          ram_raddr   = wp_q - dly_eff;
          out_valid_d = 1'b1;
          zero_d      = (fill_eff < dly_eff);
          wp_d        = wp_q + 1'b1;
          if (fill_eff < dly_eff) fill_d = fill_eff + 1'b1;
        end
        if (flush && !cfg_ok) begin
          state_d = ST_DRAIN;
          pend_d  = fill_d;
        end
      end
      ST_DRAIN: begin
        if (slot_free) begin
          if (pend_q != '0) begin
            ram_re      = 1'b1;
            ram_raddr   = wp_q - pend_q;
            out_valid_d = 1'b1;
            zero_d      = 1'b0;
            pend_d      = pend_q - 1'b1;
          end else begin
            fill_d  = '0;
            state_d = ST_RUN;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge mclk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      wp_q        <= '0;
      fill_q      <= '0;
      dly_q       <= Addr_Width'(1);
      pend_q      <= '0;
      out_valid_q <= 1'b0;
      zero_q      <= 1'b1;
      cfg_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wp_q        <= wp_d;
      fill_q      <= fill_d;
      dly_q       <= dly_d;
      pend_q      <= pend_d;
      out_valid_q <= out_valid_d;
      zero_q      <= zero_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

  dp_ram #(
    .Data_Width(Data_Width),
    .Addr_Width(Addr_Width)
  ) u_ram (
    .clk  (mclk),
    .we   (ram_we),
    .waddr(wp_q),
    .wdata(in_data),
    .re   (ram_re),
    .raddr(ram_raddr),
    .rdata(ram_rdata)
  );

  // The mask flag stands in zeros until D samples have been written.
  assign out_data  = zero_q ? '0 : ram_rdata;
  assign out_valid = out_valid_q;
  assign cfg_err   = cfg_err_q;
  assign busy      = (state_q == ST_DRAIN);
  assign state_o   = state_q;

endmodule

// File: tb/tb_delay_sched.sv
// Self-checking bench for delay_sched: directed and random steps compared every cycle
// against a queue-based model of the delay line.
module tb_delay_sched;

  localparam int DW = 12;
  localparam int AW = 3;

  logic          mclk = 1'b0;
  logic          rst  = 1'b0;
  logic          cfg_load, flush, in_valid, out_ready;
  logic [AW-1:0] cfg_delay;
  logic [DW-1:0] in_data;
  logic          cfg_err, in_ready, out_valid, busy;
  logic [DW-1:0] out_data;
  logic [1:0]    state_o;

  always #5 mclk = ~mclk;

  delay_sched #(.Data_Width(DW), .Addr_Width(AW)) dut (
    .mclk     (mclk),
    .rst      (rst),
    .cfg_load (cfg_load),
    .cfg_delay(cfg_delay),
    .cfg_err  (cfg_err),
    .flush    (flush),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_ready(out_ready),
    .busy     (busy),
    .state_o  (state_o)
  );

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  // Model: 0 idle, 1 run, 2 drain; hist holds samples accepted since the line was last emptied.
  int            m_state, m_d;
  bit            m_ov, m_err;
  logic [DW-1:0] m_od;
  logic [DW-1:0] hist[$];
  logic [DW-1:0] drain[$];

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    m_state = 0;
    m_d     = 1;
    m_ov    = 1'b0;
    m_od    = '0;
    m_err   = 1'b0;
    hist.delete();
    drain.delete();
  endtask

  task automatic applyStimulus(input bit v, input logic [DW-1:0] d, input bit ordy,
                               input bit fl, input bit cl, input logic [AW-1:0] cd);
    bit            slot, exp_rdy, ok, n_ov, n_err;
    logic [DW-1:0] n_od;
    int            cur, n_state, k;
    in_valid  = v;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    cfg_load  = cl;
    cfg_delay = cd;
    @(negedge mclk);
    slot    = !m_ov || ordy;
    exp_rdy = (m_state == 1) && slot;
    checkOutput("in_ready", in_ready, exp_rdy);
    checkOutput("out_valid", out_valid, m_ov);
    if (m_ov) checkOutput("out_data", out_data, m_od);
    checkOutput("state_o", state_o, m_state);
    checkOutput("busy", busy, m_state == 2);
    checkOutput("cfg_err", cfg_err, m_err);

    cur     = m_state;
    n_state = m_state;
    n_ov    = m_ov && !ordy;
    n_od    = m_od;
    ok      = cl && (cd != 0) && (cur == 0 || (cur == 1 && hist.size() == 0 && !m_ov));
    n_err   = cl && !ok;
    if (ok) begin
      m_d = int'(cd);
      hist.delete();
      n_state = 1;
    end
    if (cur == 1) begin
      if (v && exp_rdy) begin
        n_ov = 1'b1;
        n_od = (hist.size() >= m_d) ? hist[hist.size() - m_d] : '0;
        hist.push_back(d);
      end
      if (fl && !ok) begin
        k = (hist.size() < m_d) ? hist.size() : m_d;
        drain.delete();
        for (int i = hist.size() - k; i < hist.size(); i++) drain.push_back(hist[i]);
        hist.delete();
        n_state = 2;
      end
    end else if (cur == 2 && slot) begin
      if (drain.size() > 0) begin
        n_ov = 1'b1;
        n_od = drain.pop_front();
      end else begin
        n_state = 1;
      end
    end
    @(posedge mclk);
    #1;
    m_state = n_state;
    m_ov    = n_ov;
    m_od    = n_od;
    m_err   = n_err;
  endtask

  task automatic resetPulse();
    rst = 1'b0;
    #1;
    modelReset();
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_in_ready", in_ready, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_state", state_o, 0);
    checkOutput("rst_out_data", out_data, 0);
    checkOutput("rst_cfg_err", cfg_err, 0);
    @(posedge mclk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    flush     = 1'b0;
    cfg_load  = 1'b0;
    cfg_delay = '0;
    #3;
    resetPulse();

    // Flush while unconfigured, then a zero-delay load that must be refused.
    applyStimulus(0, 0, 1, 1, 0, 0);
    applyStimulus(0, 0, 1, 0, 1, 0);
    applyStimulus(0, 0, 1, 0, 0, 0);

    // Basic stream, D=3.
    applyStimulus(0, 0, 1, 0, 1, 3);
    for (int i = 1; i <= 6; i++) applyStimulus(1, DW'(i), 1, 0, 0, 0);
    applyStimulus(0, 0, 1, 0, 0, 0);
    applyStimulus(0, 0, 1, 0, 1, 2);
    applyStimulus(0, 0, 1, 1, 0, 0);
    repeat (5) applyStimulus(0, 0, 1, 0, 0, 0);

    // Back-pressure with D=2.
    applyStimulus(0, 0, 1, 0, 1, 2);
    for (int i = 0; i < 12; i++) applyStimulus(1, DW'($urandom), !(i >= 4 && i < 8), 0, 0, 0);
    repeat (2) applyStimulus(0, 0, 1, 0, 0, 0);
    applyStimulus(0, 0, 1, 1, 0, 0);
    repeat (5) applyStimulus(0, 0, 1, 0, 0, 0);

    // Flush with D=4, plus a load attempt during the drain.
    applyStimulus(0, 0, 1, 0, 1, 4);
    for (int i = 10; i <= 15; i++) applyStimulus(1, DW'(i), 1, 0, 0, 0);
    applyStimulus(0, 0, 1, 1, 0, 0);
    applyStimulus(0, 0, 1, 0, 1, 6);
    repeat (6) applyStimulus(0, 0, 1, 0, 0, 0);
    applyStimulus(1, 12'h0aa, 1, 0, 0, 0);
    applyStimulus(0, 0, 1, 1, 0, 0);
    repeat (4) applyStimulus(0, 0, 1, 0, 0, 0);

    // Maximum delay across pointer wrap.
    applyStimulus(0, 0, 1, 0, 1, 7);
    for (int i = 0; i < 20; i++) applyStimulus(1, DW'(100 + i), 1, 0, 0, 0);
    applyStimulus(0, 0, 1, 0, 0, 0);

    // Random traffic including flushes and load attempts.
    repeat (200)
      applyStimulus($urandom_range(0, 3) != 0, DW'($urandom), $urandom_range(0, 3) != 0,
                    $urandom_range(0, 19) == 0, $urandom_range(0, 29) == 0, AW'($urandom_range(0, 7)));

    // Reach an empty RUN line, hold a stalled output, then reset mid-stream.
    applyStimulus(0, 0, 1, 1, 0, 0);
    repeat (12) applyStimulus(0, 0, 1, 0, 0, 0);
    applyStimulus(0, 0, 1, 0, 1, 2);
    applyStimulus(1, 12'h123, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    resetPulse();
    applyStimulus(0, 0, 1, 0, 1, 1);
    applyStimulus(1, 7, 1, 0, 0, 0);
    applyStimulus(1, 8, 1, 0, 0, 0);
    repeat (2) applyStimulus(0, 0, 1, 0, 0, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
